// File: rtl/volatility_pkg.sv
// Shared widths and the per-stock accumulator record for the volatility accumulator.
// Accumulator fields are sized for DATA_WIDTH <= 64 and BUFFER_SIZE <= 1024; unused upper bits stay zero.
package volatility_pkg;

    localparam int MAX_DATA_WIDTH  = 64;
    localparam int MAX_BUFFER_SIZE = 1024;

    function automatic int sum_w(input int data_width, input int buffer_size);
        return data_width + $clog2(buffer_size) + 1;
    endfunction

    function automatic int sq_w(input int data_width, input int buffer_size);
        return 2 * data_width + $clog2(buffer_size) + 1;
    endfunction

    function automatic int var_w(input int data_width, input int buffer_size);
        return 2 * data_width + 2 * $clog2(buffer_size) + 1;
    endfunction

    function automatic int cnt_w(input int buffer_size);
        return $clog2(buffer_size) + 1;
    endfunction

    localparam int ACC_SUM_MAX = sum_w(MAX_DATA_WIDTH, MAX_BUFFER_SIZE);
    localparam int ACC_SQ_MAX  = sq_w(MAX_DATA_WIDTH, MAX_BUFFER_SIZE);
    localparam int ACC_CNT_MAX = cnt_w(MAX_BUFFER_SIZE);

    typedef struct packed {
        logic [ACC_CNT_MAX-1:0] count;
        logic [ACC_SQ_MAX-1:0]  sum_sq;
        logic [ACC_SUM_MAX-1:0] sum;
    } acc_t;

endpackage

// File: rtl/volatility_accum_if.sv
// Sample-in / result-out bundle of the volatility accumulator.
// Signal prefixes are from the accumulator's point of view (i_ = into it, o_ = out of it).
interface volatility_accum_if
    import volatility_pkg::*;
#(
    parameter int NUM_STOCKS  = 4,
    parameter int BUFFER_SIZE = 20,
    parameter int DATA_WIDTH  = 32
);
    localparam int ADDR_W = $clog2(NUM_STOCKS * BUFFER_SIZE);
    localparam int SID_W  = $clog2(NUM_STOCKS);
    localparam int SUM_W  = sum_w(DATA_WIDTH, BUFFER_SIZE);
    localparam int SQ_W   = sq_w(DATA_WIDTH, BUFFER_SIZE);
    localparam int VAR_W  = var_w(DATA_WIDTH, BUFFER_SIZE);
    localparam int CNT_W  = cnt_w(BUFFER_SIZE);

    logic                  i_addr_valid;
    logic [ADDR_W-1:0]     i_write_address;
    logic [SID_W-1:0]      i_stock_id;
    logic [DATA_WIDTH-1:0] i_price;
    logic [DATA_WIDTH-1:0] i_buffer_size;

    logic                  o_valid;
    logic [SID_W-1:0]      o_stock_id;
    logic [SUM_W-1:0]      o_sum;
    logic [SQ_W-1:0]       o_sum_sq;
    logic [CNT_W-1:0]      o_count;
    logic [VAR_W-1:0]      o_variance;

    modport master (
        output i_addr_valid, i_write_address, i_stock_id, i_price, i_buffer_size,
        input  o_valid, o_stock_id, o_sum, o_sum_sq, o_count, o_variance
    );

    modport slave (
        input  i_addr_valid, i_write_address, i_stock_id, i_price, i_buffer_size,
        output o_valid, o_stock_id, o_sum, o_sum_sq, o_count, o_variance
    );

endinterface

// File: rtl/volatility_accum_price_ram.sv
// Price sample store: one port, read-before-write, registered read, no reset.
// The read register only updates on write cycles, returning the value being overwritten.
module price_ram #(
    parameter int DEPTH      = 80,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_rdata        <= r_mem[i_addr];
            r_mem[i_addr]  <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/volatility_accum.sv
// Sliding-window sum / sum-of-squares per stock, one sample per cycle, latency 2.
// Define VOLATILITY_VARIANCE_EN to add a third stage producing count*sum_sq - sum^2 (latency 3).
module volatility_accum
    import volatility_pkg::*;
#(
    parameter int NUM_STOCKS  = 4,
    parameter int BUFFER_SIZE = 20,
    parameter int DATA_WIDTH  = 32
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    volatility_accum_if.slave  bus
);

    localparam int DEPTH  = NUM_STOCKS * BUFFER_SIZE;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int SID_W  = $clog2(NUM_STOCKS);
    localparam int SUM_W  = sum_w(DATA_WIDTH, BUFFER_SIZE);
    localparam int SQ_W   = sq_w(DATA_WIDTH, BUFFER_SIZE);
    localparam int VAR_W  = var_w(DATA_WIDTH, BUFFER_SIZE);
    localparam int CNT_W  = cnt_w(BUFFER_SIZE);

    // ---------------- stage 1: RAM read-before-write + forwarding ----------------
    logic                  r_s1_valid;
    logic [SID_W-1:0]      r_s1_stock;
    logic [DATA_WIDTH-1:0] r_s1_price;
    logic                  r_s1_fwd_hit;
    logic [DATA_WIDTH-1:0] r_s1_fwd_price;
    logic                  r_prev_valid;
    logic [ADDR_W-1:0]     r_prev_addr;
    logic [DATA_WIDTH-1:0] r_prev_price;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    logic [DATA_WIDTH-1:0] w_old;

    price_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_price_ram (
        .i_clk   (i_clk),
        .i_we    (bus.i_addr_valid),
        .i_addr  (bus.i_write_address),
        .i_wdata (bus.i_price),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_stock     <= '0;
            r_s1_price     <= '0;
            r_s1_fwd_hit   <= 1'b0;
            r_s1_fwd_price <= '0;
            r_prev_valid   <= 1'b0;
            r_prev_addr    <= '0;
            r_prev_price   <= '0;
        end else begin
            r_s1_valid <= bus.i_addr_valid;
            if (bus.i_addr_valid) begin
                r_s1_stock     <= bus.i_stock_id;
                r_s1_price     <= bus.i_price;
                r_s1_fwd_hit   <= r_prev_valid && (r_prev_addr == bus.i_write_address);
                r_s1_fwd_price <= r_prev_price;
                r_prev_valid   <= 1'b1;
                r_prev_addr    <= bus.i_write_address;
                r_prev_price   <= bus.i_price;
            end
        end
    end

    // Forwarding keeps the old value correct even if the RAM is mapped to a write-first primitive.
    assign w_old = r_s1_fwd_hit ? r_s1_fwd_price : w_ram_rdata;

    // ---------------- stage 2: per-stock accumulator update ----------------
    acc_t                  w_acc [NUM_STOCKS];
    acc_t                  w_cur;
    acc_t                  w_acc_next;
    logic [CNT_W-1:0]      w_cur_cnt;
    logic [SUM_W-1:0]      w_cur_sum;
    logic [SQ_W-1:0]       w_cur_sq;
    logic                  w_evict;
    logic [DATA_WIDTH-1:0] w_old_eff;
    logic [CNT_W-1:0]      w_next_cnt;
    logic [SUM_W-1:0]      w_next_sum;
    logic [SQ_W-1:0]       w_new_sq;
    logic [SQ_W-1:0]       w_old_sq;
    logic [SQ_W-1:0]       w_next_sq;
    logic                  w_unused_acc;

    assign w_cur        = w_acc[r_s1_stock];
    assign w_unused_acc = ^w_cur;
    assign w_cur_cnt    = w_cur.count[CNT_W-1:0];
    assign w_cur_sum    = w_cur.sum[SUM_W-1:0];
    assign w_cur_sq     = w_cur.sum_sq[SQ_W-1:0];

    // Until the window is full the slot holds a stale price from an earlier epoch; ignore it.
    assign w_evict    = DATA_WIDTH'(w_cur_cnt) >= bus.i_buffer_size;
    assign w_old_eff  = w_evict ? w_old : '0;
    assign w_next_cnt = w_evict ? w_cur_cnt : w_cur_cnt + CNT_W'(1);
    assign w_next_sum = w_cur_sum + SUM_W'(r_s1_price) - SUM_W'(w_old_eff);
    assign w_new_sq   = SQ_W'(r_s1_price) * SQ_W'(r_s1_price);
    assign w_old_sq   = SQ_W'(w_old_eff) * SQ_W'(w_old_eff);
    assign w_next_sq  = w_cur_sq + w_new_sq - w_old_sq;

    always_comb begin
        w_acc_next        = '0;
        w_acc_next.count  = ACC_CNT_MAX'(w_next_cnt);
        w_acc_next.sum    = ACC_SUM_MAX'(w_next_sum);
        w_acc_next.sum_sq = ACC_SQ_MAX'(w_next_sq);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STOCKS; gi++) begin : g_stock
            acc_t r_acc;

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_acc <= '0;
                end else if (r_s1_valid && (r_s1_stock == SID_W'(gi))) begin
                    r_acc <= w_acc_next;
                end
            end

            assign w_acc[gi] = r_acc;
        end
    endgenerate

    logic             r_s2_valid;
    logic [SID_W-1:0] r_s2_stock;
    logic [SUM_W-1:0] r_s2_sum;
    logic [SQ_W-1:0]  r_s2_sq;
    logic [CNT_W-1:0] r_s2_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_stock <= '0;
            r_s2_sum   <= '0;
            r_s2_sq    <= '0;
            r_s2_cnt   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_stock <= r_s1_stock;
                r_s2_sum   <= w_next_sum;
                r_s2_sq    <= w_next_sq;
                r_s2_cnt   <= w_next_cnt;
            end
        end
    end

`ifdef VOLATILITY_VARIANCE_EN
    // ---------------- stage 3: scaled variance ----------------
    logic             r_s3_valid;
    logic [SID_W-1:0] r_s3_stock;
    logic [SUM_W-1:0] r_s3_sum;
    logic [SQ_W-1:0]  r_s3_sq;
    logic [CNT_W-1:0] r_s3_cnt;
    logic [VAR_W-1:0] r_s3_var;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s3_valid <= 1'b0;
            r_s3_stock <= '0;
            r_s3_sum   <= '0;
            r_s3_sq    <= '0;
            r_s3_cnt   <= '0;
            r_s3_var   <= '0;
        end else begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_stock <= r_s2_stock;
                r_s3_sum   <= r_s2_sum;
                r_s3_sq    <= r_s2_sq;
                r_s3_cnt   <= r_s2_cnt;
                r_s3_var   <= VAR_W'(r_s2_cnt) * VAR_W'(r_s2_sq)
                            - VAR_W'(r_s2_sum) * VAR_W'(r_s2_sum);
            end
        end
    end

    assign bus.o_valid    = r_s3_valid;
    assign bus.o_stock_id = r_s3_stock;
    assign bus.o_sum      = r_s3_sum;
    assign bus.o_sum_sq   = r_s3_sq;
    assign bus.o_count    = r_s3_cnt;
    assign bus.o_variance = r_s3_var;
`else
    assign bus.o_valid    = r_s2_valid;
    assign bus.o_stock_id = r_s2_stock;
    assign bus.o_sum      = r_s2_sum;
    assign bus.o_sum_sq   = r_s2_sq;
    assign bus.o_count    = r_s2_cnt;
    assign bus.o_variance = '0;
`endif

endmodule
